// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm time store, edit flow, ring/snooze sequencer driving the display mux.
// Snooze path is built only when ALARM_SNOOZE_EN is defined.
module alarm_ctrl #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_alam,
  input  logic       btn_up,
  input  logic       btn_off,
  input  logic       btn_snooze,
  input  logic [7:0] time_hh,
  input  logic [7:0] time_mm,
  input  logic [7:0] time_ss,
  output logic [7:0] alarm_hh,
  output logic [7:0] alarm_mm,
  output logic       disp_sel,
  output logic [1:0] edit_field,
  output logic       armed,
  output logic       buzzer
);
  localparam logic [2:0] IDLE = 3'd0, VIEW = 3'd1, EDIT_H = 3'd2, EDIT_M = 3'd3, RING = 3'd4;
  localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);
  logic [2:0] state, state_n;
  logic [7:0] ring_cnt, ring_n, hh_n, mm_n;
  logic armed_n, snz, hit, quiet;
`ifdef ALARM_SNOOZE_EN
  localparam logic [2:0] SNOOZE = 3'd5;
  localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SECS - 1);
  logic [9:0] snooze_cnt, snooze_n;
  assign snz = btn_snooze;
`else
  logic unused_snooze;
  assign unused_snooze = btn_snooze | (SNOOZE_SECS == 0);
  assign snz = 1'b0;
`endif
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    return v == top ? 8'h00 : v[3:0] == 4'h9 ? {v[7:4] + 4'h1, 4'h0} : v + 8'h01;
  endfunction
  assign hit = armed && tick_1hz && time_hh == alarm_hh && time_mm == alarm_mm && time_ss == 8'h00;
  // a higher-priority pulse swallows btn_alam/btn_up even when it has no effect in this state
  assign quiet = !btn_off && !snz;
  always_comb begin
    state_n = state;
    ring_n = ring_cnt;
    armed_n = armed;
    hh_n = alarm_hh;
    mm_n = alarm_mm;
`ifdef ALARM_SNOOZE_EN
    snooze_n = snooze_cnt;
`endif
    case (state)
      IDLE, VIEW:
        if (hit) begin
          state_n = RING;
          ring_n = 8'd0;
        end else if (btn_off) begin
          state_n = IDLE;
          armed_n = state == IDLE ? !armed : armed;
        end else if (quiet && btn_alam) state_n = state == IDLE ? VIEW : EDIT_H;
      EDIT_H:
        if (quiet && btn_alam) state_n = EDIT_M;
        else if (quiet && btn_up) hh_n = bcd_inc(alarm_hh, 8'h23);
      EDIT_M:
        if (quiet && btn_alam) begin
          state_n = IDLE;
          armed_n = 1'b1;
        end else if (quiet && btn_up) mm_n = bcd_inc(alarm_mm, 8'h59);
      RING:
        if (btn_off) state_n = IDLE;
`ifdef ALARM_SNOOZE_EN
        else if (btn_snooze) begin
          state_n = SNOOZE;
          snooze_n = 10'd0;
        end
`endif
        else if (tick_1hz) begin
          state_n = ring_cnt == RING_LAST ? IDLE : RING;
          ring_n = ring_cnt + 8'd1;
        end
`ifdef ALARM_SNOOZE_EN
      SNOOZE:
        if (btn_off) state_n = IDLE;
        else if (tick_1hz) begin
          state_n = snooze_cnt == SNOOZE_LAST ? RING : SNOOZE;
          snooze_n = snooze_cnt + 10'd1;
          ring_n = 8'd0;
        end
`endif
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      ring_cnt <= 8'd0;
      alarm_hh <= 8'h00;
      alarm_mm <= 8'h00;
      armed <= 1'b0;
      disp_sel <= 1'b0;
      edit_field <= 2'b00;
      buzzer <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt <= 10'd0;
`endif
    end else begin
      state <= state_n;
      ring_cnt <= ring_n;
      alarm_hh <= hh_n;
      alarm_mm <= mm_n;
      armed <= armed_n;
      disp_sel <= state_n == VIEW || state_n == EDIT_H || state_n == EDIT_M;
      edit_field <= {state_n == EDIT_M, state_n == EDIT_H};
      buzzer <= state_n == RING;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt <= snooze_n;
`endif
    end
endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed and random stimulus against a seconds-remaining reference model.
module tb_alarm_ctrl;
  localparam int RS = 3, SS = 2;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n, tick_1hz, btn_alam, btn_up, btn_off, btn_snooze;
  logic [7:0] time_hh, time_mm, time_ss, alarm_hh, alarm_mm;
  logic disp_sel, armed, buzzer;
  logic [1:0] edit_field;
  int n_cmp = 0, n_bad = 0;
  typedef enum {M_IDLE, M_VIEW, M_EH, M_EM, M_RING, M_SNZ} mode_t;
  mode_t mode = M_IDLE;
  int ah = 0, am = 0, left = 0, th = 12, tm = 0, ts = 5;
  bit marm = 1'b0;
  alarm_ctrl #(.RING_SECS(RS), .SNOOZE_SECS(SS)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .btn_alam(btn_alam), .btn_up(btn_up),
    .btn_off(btn_off), .btn_snooze(btn_snooze), .time_hh(time_hh), .time_mm(time_mm),
    .time_ss(time_ss), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .disp_sel(disp_sel),
    .edit_field(edit_field), .armed(armed), .buzzer(buzzer)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model(input bit r, input bit t, input bit ba, input bit bu, input bit bo, input bit bs);
    bit hit, s;
    if (!r) begin
      mode = M_IDLE;
      ah = 0;
      am = 0;
      marm = 1'b0;
      return;
    end
    s = SNZ && bs;
    hit = marm && t && th == ah && tm == am && ts == 0;
    case (mode)
      M_IDLE, M_VIEW:
        if (hit) begin
          mode = M_RING;
          left = RS;
        end else if (bo) begin
          if (mode == M_IDLE) marm = !marm;
          mode = M_IDLE;
        end else if (!s && ba) mode = mode == M_IDLE ? M_VIEW : M_EH;
      M_EH:
        if (!bo && !s) begin
          if (ba) mode = M_EM;
          else if (bu) ah = (ah + 1) % 24;
        end
      M_EM:
        if (!bo && !s) begin
          if (ba) begin
            mode = M_IDLE;
            marm = 1'b1;
          end else if (bu) am = (am + 1) % 60;
        end
      M_RING:
        if (bo) mode = M_IDLE;
        else if (s) begin
          mode = M_SNZ;
          left = SS;
        end else if (t) begin
          left--;
          if (left == 0) mode = M_IDLE;
        end
      M_SNZ:
        if (bo) mode = M_IDLE;
        else if (t) begin
          left--;
          if (left == 0) begin
            mode = M_RING;
            left = RS;
          end
        end
      default: mode = M_IDLE;
    endcase
  endtask
  task automatic cyc(input bit r = 1, input bit t = 0, input bit ba = 0, input bit bu = 0,
                     input bit bo = 0, input bit bs = 0);
    rst_n = r;
    tick_1hz = t;
    btn_alam = ba;
    btn_up = bu;
    btn_off = bo;
    btn_snooze = bs;
    time_hh = bcd(th);
    time_mm = bcd(tm);
    time_ss = bcd(ts);
    @(posedge clk);
    model(r, t, ba, bu, bo, bs);
    #1;
    chk("alarm_hh", alarm_hh, bcd(ah));
    chk("alarm_mm", alarm_mm, bcd(am));
    chk("armed", armed, marm);
    chk("disp_sel", disp_sel, mode inside {M_VIEW, M_EH, M_EM});
    chk("edit_field", edit_field, mode == M_EH ? 1 : mode == M_EM ? 2 : 0);
    chk("buzzer", buzzer, mode == M_RING);
  endtask
  task automatic set_alarm(input int h, input int m);
    cyc(.r(0));
    cyc(.ba(1));
    cyc(.ba(1));
    repeat (h) cyc(.bu(1));
    cyc(.ba(1));
    repeat (m) cyc(.bu(1));
    cyc(.ba(1));
  endtask
  initial begin
    repeat (2) cyc(.r(0));
    chk("rst_outputs", {alarm_hh, alarm_mm, disp_sel, edit_field, armed, buzzer}, 0);
    cyc(.bo(1));
    chk("arm_toggle_on", armed, 1);
    cyc(.bo(1));
    chk("arm_toggle_off", armed, 0);
    cyc(.ba(1));
    cyc(.ba(1));
    repeat (24) cyc(.bu(1));
    chk("hh_wrap", alarm_hh, 8'h00);
    cyc(.ba(1));
    repeat (61) cyc(.bu(1));
    chk("mm_wrap", alarm_mm, 8'h01);
    cyc(.ba(1));
    chk("edit_done_armed", armed, 1);
    set_alarm(6, 30);
    th = 6;
    tm = 30;
    ts = 0;
    cyc(.t(1));
    chk("ring_start", buzzer, 1);
    cyc(.bo(1));
    ts = 1;
    repeat (3) cyc(.t(1));
    chk("no_retrigger", buzzer, 0);
    ts = 0;
    cyc(.t(1));
    ts = 1;
    repeat (2) begin
      cyc(.t(1));
      cyc();
    end
    chk("ring_before_timeout", buzzer, 1);
    cyc(.t(1));
    chk("timeout_buzzer", buzzer, 0);
    chk("timeout_armed", armed, 1);
    ts = 0;
    cyc(.t(1));
    ts = 1;
    cyc(.bs(1));
    chk("snooze_silence", buzzer, !SNZ);
    cyc(.t(1));
    cyc(.t(1));
    chk("snooze_rering", buzzer, 1);
    cyc(.bo(1));
    ts = 0;
    cyc(.t(1));
    ts = 1;
    cyc(.bo(1), .bs(1));
    chk("off_beats_snooze", buzzer, 0);
    ts = 0;
    cyc(.t(1));
    cyc(.r(0));
    chk("rst_mid_ring", {alarm_hh, alarm_mm, buzzer}, 0);
    repeat (3000) begin
      th = $urandom_range(2) == 0 ? ah : $urandom_range(23);
      tm = $urandom_range(2) == 0 ? am : $urandom_range(59);
      ts = $urandom_range(2) == 0 ? 0 : $urandom_range(59);
      cyc(.r($urandom_range(299) != 0), .t($urandom_range(1) == 1),
          .ba($urandom_range(7) == 0), .bu($urandom_range(3) == 0),
          .bo($urandom_range(15) == 0), .bs($urandom_range(9) == 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
